// File: rtl/tlb_pkg.sv
// Shared TLB constants, packed entry layout and the page-size match rule.
package tlb_pkg;
  localparam int TLBNUM  = 16;
  localparam int IDX_W   = 4;
  localparam int ENTRY_W = 89;
  localparam int VPPN_W  = 19;
  localparam int ASID_W  = 10;
  localparam int PAGE_W  = 32;

  // Bit offsets of the packed entry (MSB first).
  localparam int E_POS    = 88;
  localparam int ASID_LSB = 78;
  localparam int G_POS    = 77;
  localparam int PS_LSB   = 71;
  localparam int VPPN_LSB = 52;
  localparam int PPN0_LSB = 32;
  localparam int PPN1_LSB = 6;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  // invtlb op codes; 7..31 are reserved and leave the TLB untouched.
  localparam logic [4:0] INV_ALL0    = 5'd0;
  localparam logic [4:0] INV_ALL1    = 5'd1;
  localparam logic [4:0] INV_G       = 5'd2;
  localparam logic [4:0] INV_NG      = 5'd3;
  localparam logic [4:0] INV_ASID    = 5'd4;
  localparam logic [4:0] INV_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA   = 5'd6;

  typedef struct packed {
    logic              e;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [5:0]        ps;
    logic [VPPN_W-1:0] vppn;
    logic [19:0]       ppn0;
    logic [1:0]        plv0;
    logic [1:0]        mat0;
    logic              d0;
    logic              v0;
    logic [19:0]       ppn1;
    logic [1:0]        plv1;
    logic [1:0]        mat1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  // 4K pages compare the full vppn, 2M pages only the upper ten bits;
  // any other page size never matches.
  function automatic logic vppn_hit(input tlb_entry_t ent, input logic [VPPN_W-1:0] vppn);
    case (ent.ps)
      PS_4K:   vppn_hit = (ent.vppn == vppn);
      PS_2M:   vppn_hit = (ent.vppn[18:9] == vppn[18:9]);
      default: vppn_hit = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/tlb_match.sv
// One search port: per-entry compare, lowest-index priority pick, half select.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int N = TLBNUM
) (
  input  tlb_entry_t [N-1:0]      ents,
  input  logic [VPPN_W-1:0]       vppn,
  input  logic                    va_bit12,
  input  logic [ASID_W-1:0]       asid,
  output logic                    found,
  output logic [IDX_W-1:0]        index,
  output logic [PAGE_W-1:0]       page
);
  logic [N-1:0] hit;

  for (genvar i = 0; i < N; i++) begin : g_cmp
    assign hit[i] = ents[i].e && (ents[i].g || (ents[i].asid == asid)) && vppn_hit(ents[i], vppn);
  end

  // Scan high to low so the lowest hitting index wins, then pick the half.
  always_comb begin
    tlb_entry_t sel;
    logic       odd;
    found = 1'b0;
    index = '0;
    page  = '0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
        sel   = ents[i];
      end
    end
    odd = (sel.ps == PS_4K) ? va_bit12 : vppn[8];
    if (found) begin
      page = odd ? {sel.ppn1, sel.ps, sel.plv1, sel.mat1, sel.d1, sel.v1}
                 : {sel.ppn0, sel.ps, sel.plv0, sel.mat0, sel.d0, sel.v0};
    end
  end
endmodule

// File: rtl/tlb_core.sv
// Fully associative TLB: entry storage, write/invalidate, two registered search ports.
module tlb_core
  import tlb_pkg::*;
#(
  parameter int TLBNUM = tlb_pkg::TLBNUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s0_req,
  input  logic [VPPN_W-1:0]   s0_vppn,
  input  logic                s0_va_bit12,
  input  logic [ASID_W-1:0]   s0_asid,
  output logic                s0_found,
  output logic [IDX_W-1:0]    s0_index,
  output logic [PAGE_W-1:0]   s0_page,
  input  logic                s1_req,
  input  logic [VPPN_W-1:0]   s1_vppn,
  input  logic                s1_va_bit12,
  input  logic [ASID_W-1:0]   s1_asid,
  output logic                s1_found,
  output logic [IDX_W-1:0]    s1_index,
  output logic [PAGE_W-1:0]   s1_page,
  input  logic                we,
  input  logic [IDX_W-1:0]    w_index,
  input  logic [ENTRY_W-1:0]  w_entry,
  input  logic [IDX_W-1:0]    r_index,
  output logic [ENTRY_W-1:0]  r_entry,
  input  logic                inv_valid,
  input  logic [4:0]          inv_op,
  input  logic [ASID_W-1:0]   inv_asid,
  input  logic [VPPN_W-1:0]   inv_vppn
);
  tlb_entry_t [TLBNUM-1:0] ent_q, ent_d;
  logic       [TLBNUM-1:0] inv_hit;

  logic [1:0]                   req;
  logic [1:0][VPPN_W-1:0]       s_vppn;
  logic [1:0]                   s_bit12;
  logic [1:0][ASID_W-1:0]       s_asid;
  logic [1:0]                   m_found, found_q, found_d;
  logic [1:0][IDX_W-1:0]        m_index, index_q, index_d;
  logic [1:0][PAGE_W-1:0]       m_page,  page_q,  page_d;

  assign req     = {s1_req, s0_req};
  assign s_vppn  = {s1_vppn, s0_vppn};
  assign s_bit12 = {s1_va_bit12, s0_va_bit12};
  assign s_asid  = {s1_asid, s0_asid};

  // Searches see ent_q, i.e. contents before this cycle's write/invalidate.
  for (genvar p = 0; p < 2; p++) begin : g_port
    tlb_match #(.N(TLBNUM)) u_match (
      .ents     (ent_q),
      .vppn     (s_vppn[p]),
      .va_bit12 (s_bit12[p]),
      .asid     (s_asid[p]),
      .found    (m_found[p]),
      .index    (m_index[p]),
      .page     (m_page[p])
    );
  end

  // Which entries the current invtlb op selects.
  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_hit[i] = 1'b1;
        INV_G:              inv_hit[i] = ent_q[i].g;
        INV_NG:             inv_hit[i] = !ent_q[i].g;
        INV_ASID:           inv_hit[i] = !ent_q[i].g && (ent_q[i].asid == inv_asid);
        INV_ASID_VA:        inv_hit[i] = !ent_q[i].g && (ent_q[i].asid == inv_asid)
                                         && vppn_hit(ent_q[i], inv_vppn);
        INV_GA_VA:          inv_hit[i] = (ent_q[i].g || (ent_q[i].asid == inv_asid))
                                         && vppn_hit(ent_q[i], inv_vppn);
        default:            inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Invalidate first, then the write lands on top so it keeps w_entry's e.
  always_comb begin
    ent_d = ent_q;
    if (inv_valid) begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (inv_hit[i]) ent_d[i].e = 1'b0;
      end
    end
    if (we) ent_d[w_index] = w_entry;
  end

  // Search results only refresh on a request, otherwise hold.
  always_comb begin
    found_d = found_q;
    index_d = index_q;
    page_d  = page_q;
    for (int p = 0; p < 2; p++) begin
      if (req[p]) begin
        found_d[p] = m_found[p];
        index_d[p] = m_index[p];
        page_d[p]  = m_page[p];
      end
    end
  end

  // State registers; reset wipes every entry and the search outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q   <= '0;
      found_q <= '0;
      index_q <= '0;
      page_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      found_q <= found_d;
      index_q <= index_d;
      page_q  <= page_d;
    end
  end

  assign r_entry  = ent_q[r_index];
  assign s0_found = found_q[0];
  assign s0_index = index_q[0];
  assign s0_page  = page_q[0];
  assign s1_found = found_q[1];
  assign s1_index = index_q[1];
  assign s1_page  = page_q[1];
endmodule

// File: tb/tb_tlb_core.sv
// Directed bench for tlb_core with a search-result scoreboard.
module tb_tlb_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req, s1_req;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [31:0] s0_page, s1_page;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic [88:0] w_entry, r_entry;
  logic        inv_valid;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          port;
    logic        found;
    logic [3:0]  idx;
    logic [31:0] page;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  tlb_core dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_page(s0_page),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_page(s1_page),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn)
  );

  function automatic logic [88:0] ent(input logic e, input logic [9:0] asid, input logic g,
                                      input logic [5:0] ps, input logic [18:0] vppn,
                                      input logic [19:0] ppn0, input logic v0,
                                      input logic [19:0] ppn1, input logic [1:0] plv1,
                                      input logic [1:0] mat1, input logic d1, input logic v1);
    ent = {e, asid, g, ps, vppn, ppn0, 2'b00, 2'b00, 1'b0, v0, ppn1, plv1, mat1, d1, v1};
  endfunction

  function automatic logic [31:0] pg(input logic [19:0] ppn, input logic [5:0] ps,
                                     input logic [1:0] plv, input logic [1:0] mat,
                                     input logic d, input logic v);
    pg = {ppn, ps, plv, mat, d, v};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic srch(input bit port, input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                      input logic ef, input logic [3:0] ei, input logic [31:0] ep);
    sb_t s;
    if (port == 1'b0) begin
      s0_req = 1'b1; s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
    end else begin
      s1_req = 1'b1; s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid;
    end
    s.port = port; s.found = ef; s.idx = ei; s.page = ep;
    sbq.push_back(s);
  endtask

  // One clock with whatever was driven, then drop pulses and drain the scoreboard.
  task automatic tick();
    sb_t s;
    step();
    s0_req = 1'b0; s1_req = 1'b0; we = 1'b0; inv_valid = 1'b0;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      if (s.port == 1'b0) begin
        chk("s0_found", 128'(s0_found), 128'(s.found));
        chk("s0_index", 128'(s0_index), 128'(s.idx));
        chk("s0_page",  128'(s0_page),  128'(s.page));
      end else begin
        chk("s1_found", 128'(s1_found), 128'(s.found));
        chk("s1_index", 128'(s1_index), 128'(s.idx));
        chk("s1_page",  128'(s1_page),  128'(s.page));
      end
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [88:0] e);
    we = 1'b1; w_index = idx; w_entry = e;
    tick();
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    tick();
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input logic [88:0] exp);
    r_index = idx;
    #1;
    chk(tag, 128'(r_entry), 128'(exp));
  endtask

  task automatic rd_e(input string tag, input logic [3:0] idx, input logic exp);
    logic [88:0] v;
    r_index = idx;
    #1;
    v = r_entry;
    chk(tag, 128'(v[88]), 128'(exp));
  endtask

  logic [88:0] e0, e1, e2, e3, e5, e7, e9;

  initial begin
    reset = 1'b1;
    s0_req = 0; s0_vppn = 0; s0_va_bit12 = 0; s0_asid = 0;
    s1_req = 0; s1_vppn = 0; s1_va_bit12 = 0; s1_asid = 0;
    we = 0; w_index = 0; w_entry = 0; r_index = 0;
    inv_valid = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0;

    e3 = ent(1, 10'd5, 0, 6'd12, 19'h12345, 20'h11111, 1, 20'hABCDE, 2'd3, 2'd1, 1, 1);
    e7 = ent(1, 10'd5, 0, 6'd21, 19'h40000, 20'h22222, 1, 20'h33333, 2'd0, 2'd0, 0, 1);
    e2 = ent(1, 10'd8, 0, 6'd21, 19'h00ABC, 20'h44444, 1, 20'h77777, 2'd0, 2'd0, 0, 1);
    e9 = ent(1, 10'd8, 0, 6'd12, 19'h00ABC, 20'h66666, 1, 20'h88888, 2'd0, 2'd0, 0, 1);
    e0 = ent(1, 10'd0, 1, 6'd12, 19'h00100, 20'h00001, 1, 20'h00002, 2'd0, 2'd0, 0, 1);
    e1 = ent(1, 10'd4, 0, 6'd12, 19'h00200, 20'h00003, 1, 20'h00004, 2'd0, 2'd0, 0, 1);
    e5 = ent(1, 10'd5, 0, 6'd12, 19'h05555, 20'h99999, 1, 20'hAAAAA, 2'd0, 2'd0, 0, 1);

    // reset state
    step(); step();
    chk("rst_s0_found", 128'(s0_found), 128'(0));
    chk("rst_s1_page",  128'(s1_page),  128'(0));
    rd("rst_r_entry0", 4'd0, 89'(0));
    reset = 1'b0;

    // first cycle after reset: search accepted, misses
    srch(0, 19'h12345, 1, 10'd5, 0, 4'd0, 32'd0);
    tick();

    // 4K entry at idx 3: odd/even halves, ASID mismatch
    wr(4'd3, e3);
    rd("wr_r_entry3", 4'd3, e3);
    srch(0, 19'h12345, 1, 10'd5, 1, 4'd3, pg(20'hABCDE, 6'd12, 2'd3, 2'd1, 1, 1));
    srch(1, 19'h12345, 1, 10'd6, 0, 4'd0, 32'd0);
    tick();
    srch(0, 19'h12345, 0, 10'd5, 1, 4'd3, pg(20'h11111, 6'd12, 2'd0, 2'd0, 0, 1));
    tick();
    // no request: outputs hold despite new inputs
    s0_vppn = 19'h7FFFF; s0_asid = 10'd99;
    tick();
    chk("hold_s0_found", 128'(s0_found), 128'(1));
    chk("hold_s0_page",  128'(s0_page),  128'(pg(20'h11111, 6'd12, 2'd0, 2'd0, 0, 1)));

    // 2M entry at idx 7: half chosen by vppn[8]
    wr(4'd7, e7);
    srch(0, 19'h401FF, 0, 10'd5, 1, 4'd7, pg(20'h33333, 6'd21, 2'd0, 2'd0, 0, 1));
    srch(1, 19'h400FF, 1, 10'd5, 1, 4'd7, pg(20'h22222, 6'd21, 2'd0, 2'd0, 0, 1));
    tick();

    // two matching entries: lowest index wins, then invtlb op 6 peels them off
    wr(4'd2, e2);
    wr(4'd9, e9);
    srch(1, 19'h00ABC, 0, 10'd8, 1, 4'd2, pg(20'h44444, 6'd21, 2'd0, 2'd0, 0, 1));
    tick();
    inv(5'd6, 10'd8, 19'h00BFF);
    srch(1, 19'h00ABC, 0, 10'd8, 1, 4'd9, pg(20'h66666, 6'd12, 2'd0, 2'd0, 0, 1));
    tick();
    inv(5'd6, 10'd8, 19'h00ABC);
    srch(1, 19'h00ABC, 0, 10'd8, 0, 4'd0, 32'd0);
    tick();

    // op 4 / op 2 / reserved op
    wr(4'd0, e0);
    wr(4'd1, e1);
    inv(5'd4, 10'd4, 19'h0);
    rd_e("op4_idx1_e", 4'd1, 0);
    rd_e("op4_idx0_e", 4'd0, 1);
    inv(5'd2, 10'd0, 19'h0);
    rd_e("op2_idx0_e", 4'd0, 0);
    rd_e("op2_idx3_e", 4'd3, 1);
    inv(5'd9, 10'd5, 19'h12345);
    rd("op9_idx3", 4'd3, e3);
    rd("op9_idx7", 4'd7, e7);

    // write + invalidate-all same cycle; searches see pre-write contents
    we = 1'b1; w_index = 4'd5; w_entry = e5;
    inv_valid = 1'b1; inv_op = 5'd0; inv_asid = 10'd0; inv_vppn = 19'h0;
    srch(1, 19'h05555, 0, 10'd5, 0, 4'd0, 32'd0);
    srch(0, 19'h12345, 1, 10'd5, 1, 4'd3, pg(20'hABCDE, 6'd12, 2'd3, 2'd1, 1, 1));
    tick();
    rd("wi_idx5", 4'd5, e5);
    for (int i = 0; i < 16; i++) begin
      if (i != 5) rd_e($sformatf("wi_idx%0d_e", i), 4'(i), 0);
    end
    srch(0, 19'h05555, 0, 10'd5, 1, 4'd5, pg(20'h99999, 6'd12, 2'd0, 2'd0, 0, 1));
    tick();

    // reset with found=1 and a write/invalidate/search all pending
    reset = 1'b1;
    we = 1'b1; w_index = 4'd6; w_entry = e5;
    inv_valid = 1'b1; inv_op = 5'd2;
    s0_req = 1'b1; s0_vppn = 19'h05555; s0_va_bit12 = 0; s0_asid = 10'd5;
    s1_req = 1'b1; s1_vppn = 19'h05555; s1_va_bit12 = 0; s1_asid = 10'd5;
    step();
    we = 0; inv_valid = 0; s0_req = 0; s1_req = 0;
    chk("rst2_s0_found", 128'(s0_found), 128'(0));
    chk("rst2_s0_index", 128'(s0_index), 128'(0));
    chk("rst2_s0_page",  128'(s0_page),  128'(0));
    chk("rst2_s1_found", 128'(s1_found), 128'(0));
    for (int i = 0; i < 16; i++) rd($sformatf("rst2_r_entry%0d", i), 4'(i), 89'(0));
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
